// File: rtl/upower_exec_mem_core.sv
// Execute/memory slice of a single-cycle uPOWER core: decoder, immediate
// generator, 64-bit ALU with flags, and a doubleword data memory.
module upower_exec_mem_core #(
    parameter int N         = 64,
    parameter int MEM_WORDS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  instruction,
    input  logic [N-1:0] rd_data1,
    input  logic [N-1:0] rd_data2,
    output logic         RegDst,
    output logic         ALUSrc,
    output logic         MemToReg,
    output logic         RegWrite,
    output logic         MemRead,
    output logic         MemWrite,
    output logic         beq,
    output logic         bne,
    output logic         reg1,
    output logic         reg2,
    output logic [3:0]   ALU_OP,
    output logic [N-1:0] immediate,
    output logic [N-1:0] alu_result,
    output logic         cout,
    output logic         slt,
    output logic         overflow,
    output logic         zero_flag,
    output logic [N-1:0] mem_rdata,
    output logic [N-1:0] wb_data
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [5:0]    op;
    logic [9:0]    xo;
    logic [N-1:0]  b_op;
    logic [N:0]    add_full;
    logic [N:0]    sub_full;
    logic          lt;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_reg [MEM_WORDS];
    logic          unused_bits;

    assign op          = instruction[31:26];
    assign xo          = instruction[10:1];
    // Register-specifier fields are routed by the external register file.
    assign unused_bits = ^instruction[25:16];

    always_comb begin
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        beq      = 1'b0;
        bne      = 1'b0;
        reg1     = 1'b0;
        reg2     = 1'b0;
        ALU_OP   = 4'b0000;
        case (op)
            6'd58: begin
                RegWrite = 1'b1; MemRead = 1'b1; MemToReg = 1'b1;
                ALUSrc   = 1'b1; reg1    = 1'b1; ALU_OP   = 4'b0010;
            end
            6'd62: begin
                MemWrite = 1'b1; ALUSrc = 1'b1; reg1 = 1'b1; ALU_OP = 4'b0010;
            end
            6'd14: begin
                RegWrite = 1'b1; ALUSrc = 1'b1; reg1 = 1'b1; ALU_OP = 4'b0010;
            end
            6'd28: begin
                RegWrite = 1'b1; ALUSrc = 1'b1; RegDst = 1'b1; ALU_OP = 4'b0000;
            end
            6'd24: begin
                RegWrite = 1'b1; ALUSrc = 1'b1; RegDst = 1'b1; ALU_OP = 4'b0001;
            end
            6'd31: begin
                // Unlisted extended opcodes leave every control at zero.
                case (xo)
                    10'd266: begin reg2 = 1'b1; RegWrite = 1'b1; reg1 = 1'b1; ALU_OP = 4'b0010; end
                    10'd40:  begin reg2 = 1'b1; RegWrite = 1'b1; reg1 = 1'b1; ALU_OP = 4'b0110; end
                    10'd28:  begin reg2 = 1'b1; RegWrite = 1'b1; RegDst = 1'b1; ALU_OP = 4'b0000; end
                    10'd444: begin reg2 = 1'b1; RegWrite = 1'b1; RegDst = 1'b1; ALU_OP = 4'b0001; end
                    default: ;
                endcase
            end
            6'd19: begin beq = 1'b1; reg1 = 1'b1; ALU_OP = 4'b0110; end
            6'd20: begin bne = 1'b1; reg1 = 1'b1; ALU_OP = 4'b0110; end
            default: ;
        endcase
    end

    // DS-form displacement is already a doubleword index, so drop the low two bits.
    always_comb begin
        if (MemRead || MemWrite)
            immediate = {{(N-14){instruction[15]}}, instruction[15:2]};
        else
            immediate = {{(N-16){instruction[15]}}, instruction[15:0]};
    end

    always_comb begin
        b_op       = ALUSrc ? immediate : rd_data2;
        add_full   = {1'b0, rd_data1} + {1'b0, b_op};
        sub_full   = {1'b0, rd_data1} + {1'b0, ~b_op} + {{N{1'b0}}, 1'b1};
        lt         = $signed(rd_data1) < $signed(b_op);
        alu_result = '0;
        cout       = 1'b0;
        overflow   = 1'b0;
        case (ALU_OP)
            4'b0000: alu_result = rd_data1 & b_op;
            4'b0001: alu_result = rd_data1 | b_op;
            4'b0010: begin
                alu_result = add_full[N-1:0];
                cout       = add_full[N];
                overflow   = (rd_data1[N-1] == b_op[N-1]) && (add_full[N-1] != rd_data1[N-1]);
            end
            4'b0011: alu_result = rd_data1 ^ b_op;
            4'b0110: begin
                alu_result = sub_full[N-1:0];
                cout       = sub_full[N];
                overflow   = (rd_data1[N-1] != b_op[N-1]) && (sub_full[N-1] != rd_data1[N-1]);
            end
            4'b0111: alu_result = {{(N-1){1'b0}}, lt};
            4'b1100: alu_result = ~(rd_data1 | b_op);
            default: alu_result = '0;
        endcase
        slt       = lt;
        zero_flag = (alu_result == '0);
    end

    assign mem_addr = alu_result[AW-1:0];

    // Entries 1..10 hold a seed value of 8 after reset; writes are ignored while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++)
                mem_reg[i] <= (i >= 1 && i <= 10) ? N'(8) : '0;
        end else if (MemWrite) begin
            mem_reg[mem_addr] <= rd_data2;
        end
    end

    assign mem_rdata = MemRead ? mem_reg[mem_addr] : '0;
    assign wb_data   = MemToReg ? mem_rdata : alu_result;

endmodule

// File: tb/tb_upower_exec_mem_core.sv
// Self-checking bench for upower_exec_mem_core: decode/ALU vector table plus
// store/load, reset-held and illegal-op memory sequences via a scoreboard.
module tb_upower_exec_mem_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic [63:0] rd_data1, rd_data2;
    logic        RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite;
    logic        beq, bne, reg1, reg2;
    logic [3:0]  ALU_OP;
    logic [63:0] immediate, alu_result, mem_rdata, wb_data;
    logic        cout, slt, overflow, zero_flag;

    upower_exec_mem_core dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .beq(beq), .bne(bne),
        .reg1(reg1), .reg2(reg2), .ALU_OP(ALU_OP), .immediate(immediate),
        .alu_result(alu_result), .cout(cout), .slt(slt), .overflow(overflow),
        .zero_flag(zero_flag), .mem_rdata(mem_rdata), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    // ctrl = {RegDst,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,beq,bne,reg1,reg2,ALU_OP}
    // flags = {cout,overflow,slt,zero_flag}
    typedef struct {
        logic [31:0] inst;
        logic [63:0] a;
        logic [63:0] b;
        logic [13:0] ctrl;
        logic [63:0] imm;
        logic [63:0] alu;
        logic [3:0]  flags;
        logic [63:0] mem;
        logic [63:0] wb;
    } vec_t;

    localparam logic [13:0] C_LD   = {10'b0111100010, 4'b0010};
    localparam logic [13:0] C_STD  = {10'b0100010010, 4'b0010};
    localparam logic [13:0] C_ADDI = {10'b0101000010, 4'b0010};
    localparam logic [13:0] C_ANDI = {10'b1101000000, 4'b0000};
    localparam logic [13:0] C_ORI  = {10'b1101000000, 4'b0001};
    localparam logic [13:0] C_ADD  = {10'b0001000011, 4'b0010};
    localparam logic [13:0] C_SUBF = {10'b0001000011, 4'b0110};
    localparam logic [13:0] C_AND  = {10'b1001000001, 4'b0000};
    localparam logic [13:0] C_OR   = {10'b1001000001, 4'b0001};
    localparam logic [13:0] C_BEQ  = {10'b0000001010, 4'b0110};
    localparam logic [13:0] C_BNE  = {10'b0000000110, 4'b0110};
    localparam logic [13:0] C_NONE = 14'b0;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MAXP   = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN   = 64'h8000_0000_0000_0000;

    vec_t vecs[17];
    vec_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic [31:0] inst, input logic [63:0] a, input logic [63:0] b,
                                input logic [13:0] ctrl, input logic [63:0] imm, input logic [63:0] alu,
                                input logic [3:0] flags, input logic [63:0] mem, input logic [63:0] wb);
        vec_t v;
        v.inst = inst; v.a = a; v.b = b; v.ctrl = ctrl; v.imm = imm;
        v.alu = alu; v.flags = flags; v.mem = mem; v.wb = wb;
        return v;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s %s got=%h want=%h", tag, fld, got, want);
        end
    endtask

    // Drive one instruction after the active edge, compare at the following falling edge.
    task automatic apply(input string tag, input logic rst_v, input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        rst         = rst_v;
        instruction = v.inst;
        rd_data1    = v.a;
        rd_data2    = v.b;
        sb_q.push_back(v);
        @(negedge clk);
        e = sb_q.pop_front();
        chk(tag, "ctrl", 64'({RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite,
                              beq, bne, reg1, reg2, ALU_OP}), 64'(e.ctrl));
        chk(tag, "imm",   immediate, e.imm);
        chk(tag, "alu",   alu_result, e.alu);
        chk(tag, "flags", 64'({cout, overflow, slt, zero_flag}), 64'(e.flags));
        chk(tag, "mem",   mem_rdata, e.mem);
        chk(tag, "wb",    wb_data, e.wb);
        $display("txn %s inst=%h a=%h b=%h alu=%h wb=%h", tag, v.inst, v.a, v.b, alu_result, wb_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(32'hE8220004, 64'd2, 64'd0, C_LD, 64'd1, 64'd3, 4'b0000, 64'd8, 64'd8);
        vecs[1]  = mk(32'h3A84FFFF, 64'd4, 64'd0, C_ADDI, ONES, 64'd3, 4'b1000, 64'd0, 64'd3);
        vecs[2]  = mk(32'h7CD83839, 64'hF0, 64'h3C, C_AND, 64'h3839, 64'h30, 4'b0000, 64'd0, 64'h30);
        vecs[3]  = mk(32'h4C000000, 64'd7, 64'd7, C_BEQ, 64'd0, 64'd0, 4'b1001, 64'd0, 64'd0);
        vecs[4]  = mk(32'h4C000000, 64'd7, 64'd8, C_BEQ, 64'd0, ONES, 4'b0010, 64'd0, ONES);
        vecs[5]  = mk(32'h7C000050, MAXP, ONES, C_SUBF, 64'h50, MINN, 4'b0100, 64'd0, MINN);
        vecs[6]  = mk(32'h600000F0, 64'h0F, 64'd0, C_ORI, 64'hF0, 64'hFF, 4'b0010, 64'd0, 64'hFF);
        vecs[7]  = mk(32'h70008000, 64'h1_0000_8001, 64'd0, C_ANDI, 64'hFFFF_FFFF_FFFF_8000,
                      64'h1_0000_8000, 4'b0000, 64'd0, 64'h1_0000_8000);
        vecs[8]  = mk(32'h7C000214, MAXP, 64'd1, C_ADD, 64'h214, MINN, 4'b0100, 64'd0, MINN);
        vecs[9]  = mk(32'h7C000214, ONES, 64'd1, C_ADD, 64'h214, 64'd0, 4'b1011, 64'd0, 64'd0);
        vecs[10] = mk(32'h7C000378, 64'hA0, 64'h05, C_OR, 64'h378, 64'hA5, 4'b0000, 64'd0, 64'hA5);
        vecs[11] = mk(32'h50000000, 64'd5, 64'd3, C_BNE, 64'd0, 64'd2, 4'b1000, 64'd0, 64'd2);
        vecs[12] = mk(32'h00001234, 64'd5, 64'd6, C_NONE, 64'h1234, 64'd4, 4'b0010, 64'd0, 64'd4);
        vecs[13] = mk(32'h7C000002, 64'd5, 64'd6, C_NONE, 64'd2, 64'd4, 4'b0010, 64'd0, 64'd4);
        vecs[14] = mk(32'hE8220000, 64'd0, 64'd0, C_LD, 64'd0, 64'd0, 4'b0001, 64'd0, 64'd0);
        vecs[15] = mk(32'hE8220000, 64'd10, 64'd0, C_LD, 64'd0, 64'd10, 4'b0000, 64'd8, 64'd8);
        vecs[16] = mk(32'hE8220000, 64'd259, 64'd0, C_LD, 64'd0, 64'h103, 4'b0000, 64'd8, 64'd8);

        rst = 1'b1; instruction = 32'h0; rd_data1 = '0; rd_data2 = '0;
        repeat (2) @(posedge clk);

        // ld at address 11 sits just past the seeded range
        apply("ld_a11", 1'b0, mk(32'hE8220000, 64'd11, 64'd0, C_LD, 64'd0, 64'd11, 4'b0000, 64'd0, 64'd0));
        for (int i = 0; i < 17; i++)
            apply($sformatf("vec%0d", i), 1'b0, vecs[i]);

        // store then load
        apply("std_m4", 1'b0, mk(32'hF8A20008, 64'd2, 64'd5, C_STD, 64'd2, 64'd4, 4'b0000, 64'd0, 64'd4));
        apply("ld_m4",  1'b0, mk(32'hE8220008, 64'd2, 64'd0, C_LD, 64'd2, 64'd4, 4'b0000, 64'd5, 64'd5));

        // illegal op whose ALU result points at address 4; the following edge must not write
        apply("ill_m4", 1'b0, mk(32'h00000000, 64'd4, 64'd4, C_NONE, 64'd0, 64'd4, 4'b0000, 64'd0, 64'd4));
        apply("ld_m4b", 1'b0, mk(32'hE8220008, 64'd2, 64'd0, C_LD, 64'd2, 64'd4, 4'b0000, 64'd5, 64'd5));

        // store to address 0 then read it back
        apply("std_m0", 1'b0, mk(32'hF8A20000, 64'd0, 64'hDEAD_BEEF_0123_4567, C_STD, 64'd0, 64'd0,
                                 4'b0001, 64'd0, 64'd0));
        apply("ld_m0",  1'b0, mk(32'hE8220000, 64'd0, 64'd0, C_LD, 64'd0, 64'd0, 4'b0001,
                                 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567));

        // std with reset held: reset reload wins over the write
        apply("std_rst1", 1'b1, mk(32'hF8A20008, 64'd2, 64'h55, C_STD, 64'd2, 64'd4, 4'b0000, 64'd0, 64'd4));
        apply("std_rst2", 1'b1, mk(32'hF8A20008, 64'd2, 64'h55, C_STD, 64'd2, 64'd4, 4'b0000, 64'd0, 64'd4));
        apply("ld_rst",   1'b0, mk(32'hE8220008, 64'd2, 64'd0, C_LD, 64'd2, 64'd4, 4'b0000, 64'd8, 64'd8));
        apply("ld_m0rst", 1'b0, mk(32'hE8220000, 64'd0, 64'd0, C_LD, 64'd0, 64'd0, 4'b0001, 64'd0, 64'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
